// File: rtl/sccpu_mem_host.sv
// Memory host for the single-cycle CPU core: program loader, instruction RAM, data RAM.
// Latency: fetch and data read are combinational (zero cycles); data writes and loader writes land on the next clock edge.
// Backpressure: load_ready drops once the program is complete or instruction RAM is full; words offered then are not consumed.
//
// Ports:
//   clock, resetn            : clock and asynchronous active-low reset
//   load_valid/ready/data/last : program stream into instruction RAM (valid/ready handshake)
//   start, halt              : one-cycle pulses releasing / stopping the core
//   pc -> inst               : core instruction fetch (byte address, word aligned)
//   alu_out, data, wmem -> mem : core data access
//   cpu_resetn, running      : core reset and run indication (registered)
//   words_loaded, fault      : loaded program length, sticky out-of-range flag
// Optional build macro SCCPU_MEM_HOST_CYCLE_COUNT_EN adds run_cycles[31:0], a count of clocks spent in RUN.

module sccpu_mem_host #(
    parameter int          IMEM_DEPTH = 32,
    parameter int          DMEM_DEPTH = 32,
    parameter logic [31:0] FILL_INST  = 32'h08000000
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [31:0]                   load_data,
    input  logic                          load_last,
    input  logic                          start,
    input  logic                          halt,
    input  logic [31:0]                   pc,
    output logic [31:0]                   inst,
    input  logic [31:0]                   alu_out,
    input  logic [31:0]                   data,
    input  logic                          wmem,
    output logic [31:0]                   mem,
    output logic                          cpu_resetn,
    output logic                          running,
    output logic [$clog2(IMEM_DEPTH):0]   words_loaded,
    output logic                          fault
`ifdef SCCPU_MEM_HOST_CYCLE_COUNT_EN
    ,
    output logic [31:0]                   run_cycles
`endif
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int PW  = IAW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   words_loaded_q, words_loaded_d;
    logic            running_q, running_d;
    logic            cpu_resetn_q, cpu_resetn_d;
    logic            fault_q, fault_d;
    // Low for the first cycle after reset release so load_ready stays low
    // while resetn is asserted even though the state register reads IDLE.
    logic            live_q, live_d;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [31:0]     dmem [DMEM_DEPTH];

    logic            imem_we;
    logic [IAW-1:0]  imem_waddr;

    logic [29:0]     fetch_idx;
    logic [29:0]     data_idx;
    logic            fetch_oob;
    logic            data_oob;

    logic            unused_addr_bits;
    assign unused_addr_bits = ^{pc[1:0], alu_out[1:0]};

    // ------------------------------------------------------------------
    // Address decode shared by fetch, data port and fault detection
    // ------------------------------------------------------------------
    assign fetch_idx = pc[31:2];
    assign data_idx  = alu_out[31:2];
    assign fetch_oob = (fetch_idx >= 30'(words_loaded_q));
    assign data_oob  = (data_idx >= 30'(DMEM_DEPTH));

    always_comb begin
        inst = FILL_INST;
        if (running_q && !fetch_oob) begin
            inst = imem[fetch_idx[IAW-1:0]];
        end
    end

    // Asynchronous read: a store in the same cycle is seen only after the edge.
    always_comb begin
        mem = 32'h0;
        if (running_q && !data_oob) begin
            mem = dmem[data_idx[DAW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state, loader handshake, words_loaded
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        words_loaded_d = words_loaded_q;
        load_ready     = 1'b0;
        imem_we        = 1'b0;
        imem_waddr     = ptr_q[IAW-1:0];

        case (state_q)
            ST_IDLE: begin
                load_ready = live_q;
                if (load_valid && live_q) begin
                    imem_we    = 1'b1;
                    imem_waddr = '0;
                    ptr_d      = PW'(1);
                    if (load_last || IMEM_DEPTH == 1) begin
                        state_d        = ST_READY;
                        words_loaded_d = PW'(1);
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                load_ready = (ptr_q < PW'(IMEM_DEPTH));
                if (load_valid && load_ready) begin
                    imem_we = 1'b1;
                    ptr_d   = ptr_q + PW'(1);
                    if (load_last || ptr_d == PW'(IMEM_DEPTH)) begin
                        state_d        = ST_READY;
                        words_loaded_d = ptr_d;
                    end
                end
            end
            ST_READY: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // halt takes priority; start is meaningless here anyway
                if (halt) begin
                    state_d        = ST_IDLE;
                    ptr_d          = '0;
                    words_loaded_d = '0;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                ptr_d          = '0;
                words_loaded_d = '0;
            end
        endcase

        live_d       = 1'b1;
        running_d    = (state_d == ST_RUN);
        cpu_resetn_d = (state_d == ST_RUN);

        fault_d = fault_q;
        if (state_d == ST_IDLE && state_q != ST_IDLE) begin
            fault_d = 1'b0;
        end else if (running_q && (fetch_oob || (wmem && data_oob))) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            words_loaded_q <= '0;
            running_q      <= 1'b0;
            cpu_resetn_q   <= 1'b0;
            fault_q        <= 1'b0;
            live_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            words_loaded_q <= words_loaded_d;
            running_q      <= running_d;
            cpu_resetn_q   <= cpu_resetn_d;
            fault_q        <= fault_d;
            live_q         <= live_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM write ports (contents deliberately not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (imem_we) begin
            imem[imem_waddr] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (running_q && wmem && !data_oob) begin
            dmem[data_idx[DAW-1:0]] <= data;
        end
    end

    assign running      = running_q;
    assign cpu_resetn   = cpu_resetn_q;
    assign words_loaded = words_loaded_q;
    assign fault        = fault_q;

`ifdef SCCPU_MEM_HOST_CYCLE_COUNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    // Zeroed on the edge entering RUN, then counts every RUN clock; frozen after halt.
    always_comb begin
        run_cycles_d = run_cycles_q;
        if (state_d == ST_RUN && state_q != ST_RUN) begin
            run_cycles_d = 32'h0;
        end else if (state_q == ST_RUN) begin
            run_cycles_d = run_cycles_q + 32'h1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            run_cycles_q <= 32'h0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_sccpu_mem_host.sv
// Self-checking bench for sccpu_mem_host with randomized fetch/data traffic.
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
// A plain array model of the program, data RAM and run state provides expected values.

module tb_sccpu_mem_host;

    localparam logic [31:0] FILL = 32'h08000000;

    logic        clock = 1'b0;
    logic        resetn;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        start;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu_out;
    logic [31:0] data;
    logic        wmem;
    logic [31:0] mem;
    logic        cpu_resetn;
    logic        running;
    logic [5:0]  words_loaded;
    logic        fault;
`ifdef SCCPU_MEM_HOST_CYCLE_COUNT_EN
    logic [31:0] run_cycles;
`endif

    sccpu_mem_host dut (
        .clock        (clock),
        .resetn       (resetn),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .start        (start),
        .halt         (halt),
        .pc           (pc),
        .inst         (inst),
        .alu_out      (alu_out),
        .data         (data),
        .wmem         (wmem),
        .mem          (mem),
        .cpu_resetn   (cpu_resetn),
        .running      (running),
        .words_loaded (words_loaded),
        .fault        (fault)
`ifdef SCCPU_MEM_HOST_CYCLE_COUNT_EN
        ,
        .run_cycles   (run_cycles)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [31:0] img [32];
    logic [31:0] dm  [32];
    int          nloaded;
    bit          model_run;
    int          run_ticks;

    logic [31:0] prog6 [6];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        if (!model_run) return FILL;
        if (a >= 32'd128 || idx >= nloaded) return FILL;
        return img[idx];
    endfunction

    function automatic logic [31:0] exp_mem(input logic [31:0] a);
        if (!model_run || a >= 32'd128) return 32'h0;
        return dm[a >> 2];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (model_run) run_ticks++;
    endtask

    task automatic load_word(input logic [31:0] w, input bit last);
        load_valid = 1'b1;
        load_data  = w;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start     = 1'b0;
        model_run = 1'b1;
        run_ticks = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        prog6 = '{32'h00000827, 32'h0001102a, 32'h00421820,
                  32'h00622020, 32'h00832820, 32'h00a43020};
        resetn = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; halt = 1'b0; pc = '0; alu_out = '0; data = '0; wmem = 1'b0;
        model_run = 1'b0; nloaded = 0; run_ticks = 0;

        // ---------------- reset ----------------
        tick(); tick();
        chk("rst_load_ready", 32'(load_ready), 0);
        chk("rst_cpu_resetn", 32'(cpu_resetn), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_words_loaded", 32'(words_loaded), 0);
        chk("rst_fault", 32'(fault), 0);
        resetn = 1'b1;
        tick(); tick();
        chk("post_rst_load_ready", 32'(load_ready), 1);

        // ---------------- 6-word program ----------------
        for (int i = 0; i < 6; i++) begin
            load_word(prog6[i], i == 5);
            img[i] = prog6[i];
        end
        nloaded = 6;
        chk("ready_words_loaded", 32'(words_loaded), 6);
        chk("ready_load_ready", 32'(load_ready), 0);
        chk("ready_inst_fill", inst, exp_inst(pc));
        halt = 1'b1; tick(); halt = 1'b0;
        chk("halt_in_ready_ignored", 32'(words_loaded), 6);
        chk("halt_in_ready_running", 32'(running), 0);
        do_start();
        chk("run_running", 32'(running), 1);
        chk("run_cpu_resetn", 32'(cpu_resetn), 1);
`ifdef SCCPU_MEM_HOST_CYCLE_COUNT_EN
        chk("run_cycles_start", run_cycles, 0);
`endif

        pc = 32'h14; #1; chk("fetch_0x14", inst, 32'h00a43020);
        pc = 32'h15; #1; chk("fetch_0x15", inst, 32'h00a43020);
        for (int i = 0; i < 12; i++) begin
            pc = 32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
            #1;
            chk("fetch_rand", inst, exp_inst(pc));
            tick();
        end
        pc = 32'h0;
        chk("no_fault_inrange", 32'(fault), 0);

        // ---------------- data RAM ----------------
        wmem = 1'b1;
        for (int i = 0; i < 32; i++) begin
            alu_out = 32'(i * 4);
            data    = $urandom;
            dm[i]   = data;
            tick();
        end
        alu_out = 32'h8; data = 32'hDEADBEEF; #1;
        chk("rdw_old", mem, exp_mem(alu_out));
        tick();
        dm[2] = 32'hDEADBEEF;
        wmem = 1'b0; #1;
        chk("rdw_new", mem, 32'hDEADBEEF);
        for (int i = 0; i < 40; i++) begin
            alu_out = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            data    = $urandom;
            wmem    = 1'($urandom_range(0, 1));
            #1;
            chk("mem_rand", mem, exp_mem(alu_out));
            tick();
            if (wmem) dm[alu_out >> 2] = data;
        end
        wmem = 1'b0;
        chk("no_fault_data", 32'(fault), 0);

        pc = 32'h18; #1;
        chk("fetch_oob_fill", inst, FILL);
        tick();
        pc = 32'h0;
        chk("fetch_oob_fault", 32'(fault), 1);
`ifdef SCCPU_MEM_HOST_CYCLE_COUNT_EN
        chk("run_cycles_count", run_cycles, 32'(run_ticks));
`endif

        halt = 1'b1; tick(); halt = 1'b0;
        model_run = 1'b0; nloaded = 0;
        chk("halt_running", 32'(running), 0);
        chk("halt_cpu_resetn", 32'(cpu_resetn), 0);
        chk("halt_words_loaded", 32'(words_loaded), 0);
        chk("halt_fault_clr", 32'(fault), 0);
        chk("halt_load_ready", 32'(load_ready), 1);
        alu_out = 32'h8; #1;
        chk("idle_mem_zero", mem, 32'h0);

        // ---------------- full 32-word load ----------------
        for (int i = 0; i < 32; i++) begin
            img[i] = $urandom;
            if (i == 10) start = 1'b1;
            load_word(img[i], 1'b0);
            start = 1'b0;
            if (i == 10) chk("start_in_load_ignored", 32'(running), 0);
        end
        nloaded = 32;
        chk("full_load_ready", 32'(load_ready), 0);
        chk("full_words_loaded", 32'(words_loaded), 32);
        load_word(32'hBADBAD00, 1'b1);
        chk("extra_not_consumed", 32'(words_loaded), 32);
        do_start();
        for (int i = 0; i < 16; i++) begin
            pc = 32'($urandom_range(0, 31) * 4);
            #1;
            chk("fetch_full", inst, exp_inst(pc));
            tick();
        end
        pc = 32'h0; #1;
        chk("fetch_word0_kept", inst, img[0]);
        chk("no_fault_full", 32'(fault), 0);

        wmem = 1'b1; alu_out = 32'h80; data = $urandom; #1;
        chk("oob_read_zero", mem, 32'h0);
        tick();
        wmem = 1'b0;
        chk("oob_write_fault", 32'(fault), 1);
        alu_out = 32'h0; #1;
        chk("oob_no_alias", mem, exp_mem(alu_out));

        halt = 1'b1; start = 1'b1; tick(); halt = 1'b0; start = 1'b0;
        model_run = 1'b0; nloaded = 0;
        chk("hs_running", 32'(running), 0);
        chk("hs_cpu_resetn", 32'(cpu_resetn), 0);
        chk("hs_words_loaded", 32'(words_loaded), 0);
`ifdef SCCPU_MEM_HOST_CYCLE_COUNT_EN
        tick();
        chk("run_cycles_hold", run_cycles, 32'(run_ticks));
`endif

        // ---------------- reset mid-LOAD ----------------
        for (int i = 0; i < 3; i++) load_word($urandom, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("midload_words_loaded", 32'(words_loaded), 0);
        chk("midload_load_ready", 32'(load_ready), 0);
        chk("midload_cpu_resetn", 32'(cpu_resetn), 0);
        tick();
        resetn = 1'b1;
        tick(); tick();
        chk("midload_release_ready", 32'(load_ready), 1);
        chk("midload_release_wl", 32'(words_loaded), 0);
        chk("midload_release_running", 32'(running), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sccpu_mem_host.md
Name: sccpu_mem_host

Overview:
Memory-side counterpart to the single-cycle CPU core (sccpu_dataflow). It services the core's instruction fetch (pc -> inst) and data access (alu_out/data/wmem -> mem). It owns a program loader that streams a program into instruction RAM while holding the core in reset, then releases the core to run. It replaces the hand-driven instruction ROM and memory stimulus in system-level benches and on-board builds.

Parameters:
IMEM_DEPTH, 32, instruction RAM depth in 32-bit words (power of two)
DMEM_DEPTH, 32, data RAM depth in 32-bit words (power of two)
FILL_INST, 32'h08000000, word returned for out-of-range fetch (j 0)

Ports:
clock  input  1  system clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
load_valid  input  1  loader word valid
load_ready  output  1  loader may accept a word this cycle
load_data  input  32  program word
load_last  input  1  marks final program word
start  input  1  one-cycle pulse: release core
halt  input  1  one-cycle pulse: stop core, return to IDLE
pc  input  32  core program counter (byte address)
inst  output  32  instruction for pc
alu_out  input  32  core data byte address
data  input  32  core store data
wmem  input  1  core store enable
mem  output  32  load data for alu_out
cpu_resetn  output  1  active-low reset to core
running  output  1  high in RUN
words_loaded  output  $clog2(IMEM_DEPTH)+1  program length
fault  output  1  sticky: out-of-range fetch/access seen in RUN

Behaviour:
- Reset (async, resetn=0): state=IDLE; cpu_resetn=0, running=0, load_ready=0, words_loaded=0, fault=0, load pointer=0. RAM contents not reset.
- States: IDLE, LOAD, READY, RUN.
- IDLE: load_ready=1. load_valid=1 -> write load_data to imem[0], pointer=1, go LOAD (or READY if load_last). Pointer and words_loaded zeroed on entry to IDLE.
- LOAD: load_ready=1 while pointer<IMEM_DEPTH. Handshake = load_valid&load_ready; write imem[pointer], pointer++. load_last on handshake, or pointer reaching IMEM_DEPTH, -> READY. Words offered with load_ready=0 are not consumed.
- READY: load_ready=0; start -> RUN next edge. words_loaded=pointer.
- RUN: cpu_resetn=1, running=1 (registered, asserted first cycle in RUN). halt -> IDLE; cpu_resetn=0 on the same edge.
- start outside READY and halt outside RUN are ignored. start and halt same cycle in RUN: halt wins.
- Fetch (combinational, zero latency, required by single-cycle core): index=pc[31:2]; inst=imem[index] if index<words_loaded, else FILL_INST. pc[1:0] ignored. Outside RUN inst=FILL_INST.
- Data read (combinational): mem=dmem[alu_out[31:2]] if index<DMEM_DEPTH, else 0. Outside RUN mem=0.
- Data write: rising edge with running & wmem & index<DMEM_DEPTH -> dmem[index]=data. Read-during-write in same cycle returns old contents.
- fault: set in RUN on out-of-range fetch, or out-of-range access with wmem=1; cleared only by resetn or entry to IDLE.
- resetn asserted mid-LOAD or mid-RUN: immediate return to IDLE with cpu_resetn=0; partially loaded program discarded (words_loaded=0).

Optional Feature:
SCCPU_MEM_HOST_CYCLE_COUNT_EN: adds output run_cycles[31:0], cleared on entry to RUN and incremented each clock in RUN; it holds its value after halt, and reset clears it. Without the macro, the port and counter are absent.

Test Plan:
- Reset: resetn=0 mid-cycle -> cpu_resetn=0, running=0, load_ready=0, words_loaded=0 immediately; after release, load_ready=1.
- Load 6 words (0x00000827, 0x0001102a, 0x00421820, 0x00622020, 0x00832820, 0x00a43020), last with load_last -> READY, words_loaded=6; start -> running=1 next cycle, cpu_resetn=1.
- RUN fetch: pc=0x14 -> inst=0x00a43020; pc=0x18 -> inst=0x08000000 and fault=1 next edge; pc=0x15 -> inst=0x00a43020.
- Data: wmem=1, alu_out=0x8, data=0xDEADBEEF for one cycle -> mem=old value that cycle, mem=0xDEADBEEF the next cycle; wmem=1, alu_out=0x80 -> no write, fault=1.
- Backpressure/full: load 32 words without load_last -> READY after the 32nd, load_ready=0; a 33rd load_valid is not consumed; start in LOAD is ignored.
- halt and start together in RUN -> IDLE, cpu_resetn=0, words_loaded=0. Reset asserted mid-LOAD after 3 words -> IDLE, words_loaded=0.
